// File: rtl/alt_run_gen.sv
// Framed serial stimulus generator: start pulse, constant lead, one alternating
// run of programmed length, constant tail, then a done pulse.
module alt_run_gen #(
    parameter int LEN_W  = 5,
    parameter int LEAD_W = 4,
    parameter int TAIL_N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [LEN_W-1:0]  run_len,
    input  logic [LEAD_W-1:0] lead_len,
    input  logic              init_bit,
    output logic              start,
    output logic              dout,
    output logic              busy,
    output logic              done
);

    localparam int TAIL_W = $clog2(TAIL_N + 1);
    localparam int MAX_LW = (LEN_W > LEAD_W) ? LEN_W : LEAD_W;
    localparam int CNT_W  = (MAX_LW > TAIL_W) ? MAX_LW : TAIL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LEAD,
        S_RUN,
        S_TAIL,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    state_t             post_lead_state;
    logic [CNT_W-1:0]   cnt_q, cnt_d, post_lead_cnt;
    logic [LEN_W-1:0]   run_len_q, run_len_d;
    logic [LEAD_W-1:0]  lead_len_q, lead_len_d;
    logic               init_q, init_d;
    logic               start_q, start_d;
    logic               dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            run_len_q  <= '0;
            lead_len_q <= '0;
            init_q     <= 1'b0;
            start_q    <= 1'b0;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_len_q  <= run_len_d;
            lead_len_q <= lead_len_d;
            init_q     <= init_d;
            start_q    <= start_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Where the frame goes once the lead (possibly empty) is finished.
    always_comb begin
        if (run_len_q != '0) begin
            post_lead_state = S_RUN;
            post_lead_cnt   = CNT_W'(run_len_q);
        end else begin
            post_lead_state = S_TAIL;
            post_lead_cnt   = CNT_W'(TAIL_N);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_len_d  = run_len_q;
        lead_len_d = lead_len_q;
        init_d     = init_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d    = S_START;
                    run_len_d  = run_len;
                    lead_len_d = lead_len;
                    init_d     = init_bit;
                end
            end
            S_START: begin
                if (lead_len_q != '0) begin
                    state_d = S_LEAD;
                    cnt_d   = CNT_W'(lead_len_q);
                end else begin
                    state_d = post_lead_state;
                    cnt_d   = post_lead_cnt;
                end
            end
            S_LEAD: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = post_lead_state;
                    cnt_d   = post_lead_cnt;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_TAIL;
                    cnt_d   = CNT_W'(TAIL_N);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_TAIL: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        start_d = (state_d == S_START);
        busy_d  = (state_d inside {S_START, S_LEAD, S_RUN, S_TAIL});
        done_d  = (state_d == S_DONE);
        dout_d  = dout_q;
        if (state_d == S_START) begin
            dout_d = init_d;
        end else if (state_d == S_RUN) begin
            dout_d = ~dout_q;
        end
    end

    assign start = start_q;
    assign dout  = dout_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_alt_run_gen.sv
// Directed bench for alt_run_gen: records output waveforms per frame and
// compares them against hand-computed bit patterns and run lengths.
module tb_alt_run_gen;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       req      = 1'b0;
    logic [4:0] run_len  = '0;
    logic [3:0] lead_len = '0;
    logic       init_bit = 1'b0;
    logic       start, dout, busy, done;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] st_v, do_v, bz_v, dn_v;

    alt_run_gen #(.LEN_W(5), .LEAD_W(4), .TAIL_N(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .run_len  (run_len),
        .lead_len (lead_len),
        .init_bit (init_bit),
        .start    (start),
        .dout     (dout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [4:0] rl, input logic [3:0] ll, input logic ib);
        run_len  = rl;
        lead_len = ll;
        init_bit = ib;
        req      = 1'b1;
        tick();
    endtask

    // Sample n cycles; bit i of each vector is frame cycle i.
    task automatic rec(input int n, input int req_off, input int chg_at, input logic [4:0] rl_new);
        st_v = '0; do_v = '0; bz_v = '0; dn_v = '0;
        for (int i = 0; i < n; i++) begin
            st_v[i] = start;
            do_v[i] = dout;
            bz_v[i] = busy;
            dn_v[i] = done;
            if (i == req_off) req = 1'b0;
            if (i == chg_at) run_len = rl_new;
            tick();
        end
    endtask

    function automatic logic [63:0] mask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic int toggles(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (do_v[i] != do_v[i-1]) c++;
        return c;
    endfunction

    // Longest stretch of back-to-back toggles: what the run detector would report.
    function automatic int streak(input int lo, input int hi);
        int cur = 0;
        int best = 0;
        for (int i = lo; i <= hi; i++) begin
            if (do_v[i] != do_v[i-1]) cur++;
            else cur = 0;
            if (cur > best) best = cur;
        end
        return best;
    endfunction

    initial begin
        tick();
        tick();
        check("rst_start", 64'(start), 64'd0);
        check("rst_dout",  64'(dout),  64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 64'({start, busy, done}), 64'd0);

        // Basic frame
        launch(5'd5, 4'd3, 1'b0);
        rec(13, 0, -1, 5'd0);
        check("s1_start",  st_v & mask(13), 64'h1);
        check("s1_dout",   do_v & mask(11), 64'b11101010000);
        check("s1_busy",   bz_v & mask(13), 64'h7FF);
        check("s1_done",   dn_v & mask(13), 64'h800);
        check("s1_tog",    64'(toggles(1, 11)), 64'd5);
        check("s1_streak", 64'(streak(1, 11)), 64'd5);

        // Zero run, zero lead
        launch(5'd0, 4'd0, 1'b1);
        rec(5, 0, -1, 5'd0);
        check("s2_start", st_v & mask(5), 64'h1);
        check("s2_dout",  do_v & mask(4), 64'hF);
        check("s2_busy",  bz_v & mask(5), 64'h7);
        check("s2_done",  dn_v & mask(5), 64'h8);
        check("s2_tog",   64'(toggles(1, 3)), 64'd0);

        // Maximum run and lead
        launch(5'd31, 4'd15, 1'b1);
        rec(51, 0, -1, 5'd0);
        check("s3_start",  st_v & mask(51), 64'h1);
        check("s3_lead",   64'(do_v[15]), 64'd1);
        check("s3_first",  64'(do_v[16]), 64'd0);
        check("s3_tail",   64'(do_v[48]), 64'd0);
        check("s3_tog",    64'(toggles(1, 49)), 64'd31);
        check("s3_streak", 64'(streak(1, 49)), 64'd31);
        check("s3_busy",   bz_v & mask(51), mask(49));
        check("s3_done",   dn_v & mask(51), 64'd1 << 49);

        // req held through the frame, run_len changed mid-frame
        launch(5'd5, 4'd3, 1'b0);
        rec(30, 13, 2, 5'd9);
        check("s4_start",   st_v & mask(30), (64'd1 << 13) | 64'd1);
        check("s4_dout1",   do_v & mask(11), 64'b11101010000);
        check("s4_tog1",    64'(toggles(1, 11)), 64'd5);
        check("s4_done",    dn_v & mask(30), (64'd1 << 11) | (64'd1 << 28));
        check("s4_busy",    bz_v & mask(30), mask(11) | (mask(28) & ~mask(13)));
        check("s4_tog2",    64'(toggles(14, 28)), 64'd9);
        check("s4_streak2", 64'(streak(14, 28)), 64'd9);

        // Asynchronous reset during the third RUN cycle
        launch(5'd5, 4'd3, 1'b0);
        req = 1'b0;
        repeat (6) tick();
        check("s5_pre", 64'({busy, dout}), 64'b11);
        #2 rst = 1'b1;
        #1 check("s5_rst_now", 64'({start, dout, busy, done}), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        rec(6, -1, -1, 5'd0);
        check("s5_quiet", (st_v | do_v | bz_v | dn_v) & mask(6), 64'd0);
        launch(5'd5, 4'd3, 1'b0);
        rec(13, 0, -1, 5'd0);
        check("s5_start", st_v & mask(13), 64'h1);
        check("s5_dout",  do_v & mask(11), 64'b11101010000);
        check("s5_done",  dn_v & mask(13), 64'h800);

        // Back-to-back frames
        launch(5'd4, 4'd2, 1'b0);
        rec(25, 11, 0, 5'd7);
        check("s6_start",   st_v & mask(25), (64'd1 << 11) | 64'd1);
        check("s6_done",    dn_v & mask(25), (64'd1 << 9) | (64'd1 << 23));
        check("s6_tog1",    64'(toggles(1, 9)), 64'd4);
        check("s6_streak1", 64'(streak(1, 9)), 64'd4);
        check("s6_tog2",    64'(toggles(12, 23)), 64'd7);
        check("s6_streak2", 64'(streak(12, 23)), 64'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alt_run_gen.md
Name: alt_run_gen

Overview:
Serial stimulus generator. It emits a framed single-bit stream containing exactly one alternating (toggling) run of a programmed length. Each frame starts with a one-cycle start pulse. The block drives the serial input and start pin of the maximum-alternating-run detector, either in self-test or on the exam bench. The detector's reported length must equal the programmed run length.

Parameters:
LEN_W, 5, width of run_len; maximum run length 2^LEN_W-1 toggles
LEAD_W, 4, width of lead_len; constant bits emitted before the run
TAIL_N, 2, constant bits emitted after the run, before done

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
req  in  1  frame request; sampled only in IDLE
run_len  in  LEN_W  number of toggles in the alternating run; captured on accept
lead_len  in  LEAD_W  constant-bit count before the run; captured on accept
init_bit  in  1  level of the start/lead bits; captured on accept
start  out  1  one-cycle frame-start pulse, aligned with the first stream bit
dout  out  1  serial stream bit (registered)
busy  out  1  high from the START cycle through the last TAIL cycle
done  out  1  one-cycle pulse after the last TAIL bit

Behaviour:
- All outputs are registered.
- Async reset (rst=1) forces: state=IDLE, start=0, dout=0, busy=0, done=0, all counters 0. This applies immediately and at any time, including mid-frame. No partial frame resumes after reset release.
- FSM states: IDLE, START, LEAD, RUN, TAIL, DONE.
- IDLE:
  - Outputs start=0, busy=0, done=0; dout holds its last value (0 after reset).
  - req=1 at a clock edge captures run_len, lead_len and init_bit, then moves to START.
  - req=0 stays in IDLE.
- START (1 cycle):
  - start=1, busy=1, dout=init_bit.
  - Next state is LEAD if lead_len>0, else RUN if run_len>0, else TAIL.
- LEAD (lead_len cycles):
  - dout=init_bit, start=0.
  - A down-counter loaded with lead_len; leave when it reaches 1.
  - Next state is RUN if run_len>0, else TAIL.
- RUN (run_len cycles):
  - Each cycle dout = ~dout of the previous cycle. The first RUN bit is therefore ~init_bit.
  - A counter loaded with run_len; leave to TAIL after the last toggle.
- TAIL (TAIL_N cycles):
  - dout holds the last RUN bit, or init_bit if run_len=0.
- DONE (1 cycle):
  - done=1, busy=0, dout holds.
  - Returns to IDLE.
  - req is ignored in the DONE cycle.
  - The earliest next accept is the first IDLE cycle, so one dead cycle separates frames.
- req during any state other than IDLE is ignored, and the captured parameters stay stable for the whole frame.
- Frame length, from the start cycle to the last TAIL bit inclusive: 1 + lead_len + run_len + TAIL_N cycles. done follows one cycle later.
- Stream property: within the frame, the number of cycles where dout differs from the previous cycle's dout:
  - is exactly run_len, all consecutive;
  - excludes the START bit relative to the pre-frame level.
- Width rule:
  - run_len=2^LEN_W-1 is legal and must not wrap.
  - Counters are LEN_W and LEAD_W bits wide; compare on 1, never decrement past 0.
- run_len=0 and lead_len=0 together: START, then TAIL×TAIL_N, then DONE. dout is constant at init_bit throughout.

Test Plan:
1. Basic frame: rst pulse, then req=1 with run_len=5, lead_len=3, init_bit=0.
   - Required: start high on frame cycle 0 only.
   - dout sequence 0,0,0,0,1,0,1,0,1,1,1.
   - done on cycle 11; busy high on cycles 0–10.
   - The detector fed by start/dout reports length=5.
2. Zero run: run_len=0, lead_len=0, init_bit=1.
   - Required: dout=1,1,1 (START plus 2 TAIL), then done.
   - Zero toggles; the detector reports 0.
3. Maximum run: run_len=31, lead_len=15, init_bit=1.
   - Required: 31 consecutive toggles, first toggle bit 0, no counter wrap.
   - Frame length 49 cycles; the detector reports 31.
4. Ignored request: req held high for the whole frame of scenario 1, with run_len changed to 9 mid-frame.
   - Required: the frame still contains 5 toggles.
   - req is ignored in DONE; the next start comes on the 2nd cycle after done, with run_len=9.
5. Reset mid-RUN: assert rst asynchronously (between edges) during the 3rd RUN cycle of scenario 1.
   - Required: start/dout/busy/done drop to 0 immediately.
   - After release with req=0, the block stays in IDLE with no further toggles.
   - A following req produces a complete fresh frame.
6. Back-to-back frames: two accepted requests (run_len=4 then 7).
   - Required: exactly one IDLE cycle between done and the second start.
   - The detector reports 4, then 7 after the second start.
